// File: rtl/muldiv_unit_if.sv
// Handshake/operand bundle between execute-stage control and the mul/div unit.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, a, b,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit with start/busy/done handshake.
// Fixed latency of XLEN/UNROLL + 2 cycles for every operation.
module muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input logic         clk,
  input logic         reset,
  muldiv_unit_if.slave bus
);
  localparam int ITER = XLEN / UNROLL;
  localparam int CW   = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, PREP, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]        op;
  logic [XLEN-1:0]   a_q, b_q, dvs, result_q;
  logic [2*XLEN-1:0] acc, step;
  logic [CW-1:0]     cnt;
  logic              neg_res, neg_rem, b_zero;

  logic              a_signed, b_signed, sgn_a, sgn_b;
  logic [XLEN-1:0]   abs_a, abs_b;
  logic [XLEN:0]     r_sh, diff, sum;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, res_nxt;

  // Operand sign interpretation and magnitudes used when loading the datapath.
  always_comb begin
    a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    sgn_a    = a_signed & a_q[XLEN-1];
    sgn_b    = b_signed & b_q[XLEN-1];
    abs_a    = sgn_a ? -a_q : a_q;
    abs_b    = sgn_b ? -b_q : b_q;
  end

  // UNROLL iterations per cycle. acc holds {hi, lo}: product halves for multiply,
  // {remainder, dividend/quotient} for restoring divide.
  always_comb begin
    step = acc;
    r_sh = '0;
    diff = '0;
    sum  = '0;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      if (op[2]) begin
        r_sh = {step[2*XLEN-1:XLEN], step[XLEN-1]};
        diff = r_sh - {1'b0, dvs};
        if (!diff[XLEN]) step = {diff[XLEN-1:0], step[XLEN-2:0], 1'b1};
        else             step = {r_sh[XLEN-1:0], step[XLEN-2:0], 1'b0};
      end else begin
        sum  = {1'b0, step[2*XLEN-1:XLEN]} + (step[0] ? {1'b0, dvs} : '0);
        step = {sum, step[XLEN-1:1]};
      end
    end
  end

  // Sign fix-up and result selection applied to the final iteration's value,
  // so the registered result is valid in the DONE cycle itself.
  always_comb begin
    prod = neg_res ? -step : step;
    quo  = b_zero ? '1 : (neg_res ? -step[XLEN-1:0] : step[XLEN-1:0]);
    rem  = b_zero ? a_q : (neg_rem ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN]);
    case (op)
      3'b000:                 res_nxt = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res_nxt = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         res_nxt = quo;
      default:                res_nxt = rem;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = PREP;
      PREP: state_nxt = CALC;
      CALC: if (cnt == '0) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers: capture, load, iterate, register result.
  always_ff @(posedge clk) begin
    if (reset) begin
      op       <= '0;
      a_q      <= '0;
      b_q      <= '0;
      dvs      <= '0;
      acc      <= '0;
      cnt      <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      b_zero   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          op  <= bus.funct3;
          a_q <= bus.a;
          b_q <= bus.b;
        end
        PREP: begin
          acc     <= {{XLEN{1'b0}}, abs_a};
          dvs     <= abs_b;
          cnt     <= CW'(ITER - 1);
          neg_res <= sgn_a ^ sgn_b;
          neg_rem <= sgn_a;
          b_zero  <= (b_q == '0);
        end
        CALC: begin
          acc <= step;
          cnt <= cnt - 1'b1;
          if (cnt == '0) result_q <= res_nxt;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: one UNROLL=1 and one UNROLL=4 instance,
// expected results queued at issue and compared when done is seen.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(32)) if1 ();
  muldiv_unit_if #(.XLEN(32)) if4 ();

  muldiv_unit #(.XLEN(32), .UNROLL(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  muldiv_unit #(.XLEN(32), .UNROLL(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));

  typedef struct { int u; logic [31:0] v; } exp_t;
  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  function automatic int lat(input int u);
    return (u == 0) ? 34 : 10;
  endfunction

  function automatic logic get_done(input int u);
    return (u == 0) ? if1.done : if4.done;
  endfunction

  function automatic logic get_busy(input int u);
    return (u == 0) ? if1.busy : if4.busy;
  endfunction

  function automatic logic [31:0] get_result(input int u);
    return (u == 0) ? if1.result : if4.result;
  endfunction

  task automatic drive(input int u, input logic s, input logic [2:0] f,
                       input logic [31:0] x, input logic [31:0] y);
    if (u == 0) begin
      if1.start = s; if1.funct3 = f; if1.a = x; if1.b = y;
    end else begin
      if4.start = s; if4.funct3 = f; if4.a = x; if4.b = y;
    end
  endtask

  // Reference behaviour from 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x,
                                        input logic [31:0] y);
    logic signed [63:0] sx, sy, sp;
    logic [63:0] up;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    up = {32'b0, x} * {32'b0, y};
    sp = '0;
    case (f)
      MUL:    return up[31:0];
      MULH:   begin sp = sx * sy; return sp[63:32]; end
      MULHSU: begin sp = sx * $signed({32'b0, y}); return sp[63:32]; end
      MULHU:  return up[63:32];
      DIV:    begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        sp = sx / sy; return sp[31:0];
      end
      DIVU:   return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      REM:    begin
        if (y == 32'd0) return x;
        sp = sx % sy; return sp[31:0];
      end
      default: return (y == 32'd0) ? x : x % y;
    endcase
  endfunction

  // Issue one op, wait (bounded) for done, check latency, busy, result and hold.
  task automatic run_op(input int u, input logic [2:0] f, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] e,
                        input bit chk_hold, input logic [31:0] hold, input string name);
    exp_t t;
    int cyc;
    bit seen, busy_ok, hold_ok;
    t.u = u; t.v = e;
    sb.push_back(t);
    drive(u, 1'b1, f, x, y);
    @(posedge clk); #1;
    drive(u, 1'b0, f, x, y);
    cyc = 1; seen = 0; busy_ok = 1; hold_ok = 1;
    while (cyc <= 200) begin
      if (get_busy(u) !== 1'b1) busy_ok = 0;
      if (get_done(u) === 1'b1) begin seen = 1; break; end
      if (chk_hold && get_result(u) !== hold) hold_ok = 0;
      @(posedge clk); #1;
      cyc++;
    end
    n_vec++;
    if (!seen || cyc != lat(u)) begin
      $display("FAIL %s latency u%0d: got %0d (seen=%0d), expected %0d", name, u, cyc, seen, lat(u));
      n_err++;
    end
    t = sb.pop_front();
    if (seen) begin
      n_vec++;
      if (t.u != u || get_result(u) !== t.v) begin
        $display("FAIL %s result u%0d: got %h, expected %h", name, u, get_result(u), t.v);
        n_err++;
      end
    end
    n_vec++;
    if (!busy_ok) begin
      $display("FAIL %s busy u%0d: busy dropped before done, expected 1", name, u);
      n_err++;
    end
    if (chk_hold) begin
      n_vec++;
      if (!hold_ok) begin
        $display("FAIL %s hold u%0d: result changed before done, expected %h", name, u, hold);
        n_err++;
      end
    end
    @(posedge clk); #1;
    n_vec++;
    if (get_done(u) !== 1'b0 || get_busy(u) !== 1'b0 || get_result(u) !== e) begin
      $display("FAIL %s post-done u%0d: done=%b busy=%b result=%h, expected 0 0 %h",
               name, u, get_done(u), get_busy(u), get_result(u), e);
      n_err++;
    end
  endtask

  task automatic test_reset();
    bit quiet;
    reset = 1'b1;
    drive(0, 1'b0, 3'b000, 32'd0, 32'd0);
    drive(1, 1'b0, 3'b000, 32'd0, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    for (int u = 0; u < 2; u++) begin
      n_vec++;
      if (get_busy(u) !== 1'b0 || get_done(u) !== 1'b0 || get_result(u) !== 32'd0) begin
        $display("FAIL reset u%0d: busy=%b done=%b result=%h, expected 0 0 0",
                 u, get_busy(u), get_done(u), get_result(u));
        n_err++;
      end
    end
    reset = 1'b0;
    quiet = 1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (if1.busy !== 1'b0 || if1.done !== 1'b0 || if4.busy !== 1'b0 || if4.done !== 1'b0)
        quiet = 0;
    end
    n_vec++;
    if (!quiet) begin
      $display("FAIL idle: activity seen without start, expected none");
      n_err++;
    end
  endtask

  task automatic test_mul_family(input int u);
    run_op(u, MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, '0, "mul");
    run_op(u, MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, '0, "mulhu");
    run_op(u, MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, '0, "mulh");
    run_op(u, MULHSU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 0, '0, "mulhsu");
  endtask

  task automatic test_div_family(input int u);
    run_op(u, DIV,  32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 0, '0, "div");
    run_op(u, REM,  32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 0, '0, "rem");
    run_op(u, DIVU, 32'd20,        32'd3, 32'd6,         0, '0, "divu");
    run_op(u, REMU, 32'd20,        32'd3, 32'd2,         0, '0, "remu");
  endtask

  task automatic test_corners(input int u);
    run_op(u, DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 0, '0, "div0");
    run_op(u, REM,  32'd5,         32'd0,         32'd5,         0, '0, "rem0");
    run_op(u, DIVU, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 0, '0, "divu0");
    run_op(u, REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 0, '0, "remneg0");
    run_op(u, DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, '0, "divovf");
    run_op(u, REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0, '0, "removf");
  endtask

  task automatic test_random(input int u);
    logic [31:0] x, y;
    logic [2:0] f;
    for (int i = 0; i < 8; i++) begin
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      f = 3'($urandom_range(0, 7));
      run_op(u, f, x, y, model(f, x, y), 0, '0, "random");
    end
  endtask

  task automatic test_handshake();
    exp_t t;
    int ndone, first_cyc;
    logic [31:0] first_res;
    t.u = 0; t.v = 32'd14;
    sb.push_back(t);
    drive(0, 1'b1, DIVU, 32'd100, 32'd7);
    @(posedge clk); #1;
    drive(0, 1'b0, DIVU, 32'd100, 32'd7);
    ndone = 0; first_cyc = 0; first_res = '0;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      if (cyc == 10) drive(0, 1'b1, MUL, 32'd3, 32'd5);
      if (cyc == 11) drive(0, 1'b0, MUL, 32'd3, 32'd5);
      if (if1.done === 1'b1) begin
        if (ndone == 0) begin first_cyc = cyc; first_res = if1.result; end
        ndone++;
      end
      @(posedge clk); #1;
    end
    t = sb.pop_front();
    n_vec++;
    if (ndone != 1 || first_cyc != 34) begin
      $display("FAIL handshake done count: got %0d at cycle %0d, expected 1 at 34", ndone, first_cyc);
      n_err++;
    end
    n_vec++;
    if (first_res !== t.v) begin
      $display("FAIL handshake result: got %h, expected %h", first_res, t.v);
      n_err++;
    end
  endtask

  task automatic test_back_to_back(input int u);
    run_op(u, DIVU, 32'd20, 32'd3, 32'd6, 0, '0, "b2b_first");
    run_op(u, MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1, 32'd6, "b2b_second");
  endtask

  task automatic test_reset_mid_op();
    bit quiet;
    drive(0, 1'b1, DIV, 32'hFFFF_FFEC, 32'd3);
    @(posedge clk); #1;
    drive(0, 1'b0, DIV, 32'hFFFF_FFEC, 32'd3);
    for (int cyc = 1; cyc < 15; cyc++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (if1.busy !== 1'b0 || if1.done !== 1'b0 || if1.result !== 32'd0) begin
      $display("FAIL reset_mid_op: busy=%b done=%b result=%h, expected 0 0 0",
               if1.busy, if1.done, if1.result);
      n_err++;
    end
    reset = 1'b0;
    quiet = 1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (if1.done !== 1'b0 || if1.busy !== 1'b0) quiet = 0;
    end
    n_vec++;
    if (!quiet) begin
      $display("FAIL reset_mid_op: done/busy seen after abort, expected none");
      n_err++;
    end
  endtask

  initial begin
    test_reset();
    for (int u = 0; u < 2; u++) begin
      test_mul_family(u);
      test_div_family(u);
      test_corners(u);
      test_random(u);
      test_back_to_back(u);
    end
    test_handshake();
    test_reset_mid_op();
    n_vec++;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
      n_err++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit implementing the RV32M/RV64M operation set, selected by funct3.
- Sits beside the single-cycle ALU in the execute stage. Control asserts start when a decoded R-type instruction has funct7 = 0000001.
- Generalises the ALU decode with width and throughput parameters and adds multi-cycle operation with a start/busy/done handshake.

Parameters:
- XLEN, 32, operand and result width in bits; must be 32 or 64.
- UNROLL, 1, bits processed per CALC cycle; must be 1, 2 or 4 and must divide XLEN.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request new operation; sampled only in IDLE.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  XLEN  rs1 operand; captured with start.
- b  input  XLEN  rs2 operand; captured with start.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle inclusive.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  registered result; holds its value until the next accepted start.

Behaviour:
- Reset (synchronous): state = IDLE, busy = 0, done = 0, result = 0, all internal registers cleared. Reset asserted mid-operation aborts the operation; no done pulse follows.
- FSM states: IDLE -> PREP -> CALC -> DONE -> IDLE.
- IDLE: start = 1 latches funct3, a and b; next state PREP. Otherwise remain in IDLE.
- PREP: compute operand signs and absolute values.
  - Signed operands: MULH a,b; MULHSU a only; DIV/REM a,b.
  - MUL treats both operands as unsigned; the low half is identical for either sign interpretation.
  - Load iteration counter = XLEN/UNROLL - 1.
- CALC: one iteration per cycle, UNROLL bits each.
  - Multiply: shift-add into a 2*XLEN accumulator.
  - Divide: restoring division of |a| by |b|.
  - When the counter reaches 0, next state is DONE.
- DONE: apply sign fix-up, register result, done = 1 for exactly this cycle; next state IDLE.
- Fixed latency for all ops: start sampled at edge 0; done high in cycle XLEN/UNROLL + 2. XLEN=32, UNROLL=1 gives 34.
- Result selection:
  - MUL: low XLEN bits of the product.
  - MULH, MULHSU, MULHU: high XLEN bits of the product.
  - DIV, DIVU: quotient.
  - REM, REMU: remainder.
- Signed fix-up:
  - Product negated if the operand signs differ.
  - Quotient negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero (b = 0), no trap, same fixed latency:
  - DIV and DIVU return all-ones.
  - REM and REMU return a.
- Signed overflow (a = 100..0, b = all-ones):
  - DIV returns a.
  - REM returns 0.
- start while busy is ignored. A new start is accepted in the IDLE cycle after DONE, so back-to-back throughput is one op per latency + 1 cycles.
- result changes only in the DONE cycle or on reset.

Test Plan:
- Reset then idle: assert reset 2 cycles, start=0 -> busy=0, done=0, result=0; no activity for 50 cycles.
- Multiply family (XLEN=32, UNROLL=1):
  - MUL a=7, b=-3 -> result 0xFFFFFFEB, done in cycle 34 after start.
  - MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE.
  - MULH a=-1, b=-1 -> 0x00000000.
  - MULHSU a=-1, b=2 -> 0xFFFFFFFF.
- Divide family:
  - DIV a=-20, b=3 -> 0xFFFFFFFA (-6).
  - REM a=-20, b=3 -> 0xFFFFFFFE (-2).
  - DIVU a=20, b=3 -> 6.
  - REMU a=20, b=3 -> 2.
- Corner cases:
  - DIV a=5, b=0 -> 0xFFFFFFFF.
  - REM a=5, b=0 -> 5.
  - DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000.
  - REM a=0x80000000, b=0xFFFFFFFF -> 0.
- Handshake: pulse start again at cycle 10 while busy -> ignored, exactly one done. Start in the IDLE cycle right after DONE -> accepted; previous result held until the new DONE.
- Reset mid-op and UNROLL: assert reset at cycle 15 of a DIV -> no done, busy=0, result=0 next cycle. Rerun the multiply and divide cases with UNROLL=4 -> same results, done in cycle 10.
